// File: rtl/plcp_pkg.sv
// Shared definitions for the DSSS PLCP receive/transmit path: FSM encoding,
// error codes, CRC-16 constants and header field layout.
package plcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SFD_SEARCH = 3'd1,
    ST_HEADER     = 3'd2,
    ST_CHECK      = 3'd3,
    ST_PSDU       = 3'd4,
    ST_DONE       = 3'd5
  } plcp_state_t;

  localparam logic [1:0] ERR_SFD_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CRC         = 2'd1;
  localparam logic [1:0] ERR_SIGNAL      = 2'd2;
  localparam logic [1:0] ERR_LENGTH      = 2'd3;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [15:0] CRC_PRESET = 16'hFFFF;

  localparam logic [5:0] HDR_SIGNAL_OFS  = 6'd0;
  localparam logic [5:0] HDR_SERVICE_OFS = 6'd8;
  localparam logic [5:0] HDR_LENGTH_OFS  = 6'd16;
  localparam logic [5:0] HDR_CRC_OFS     = 6'd32;
  localparam logic [5:0] HDR_LAST_BIT    = 6'd47;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16-CCITT engine; init reloads the preset, en folds in one bit.
module crc16_ccitt_serial
  import plcp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_PRESET;
    end else if (init) begin
      crc <= CRC_PRESET;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/plcp_rx_controller.sv
// 1 Mbps DSSS PLCP receive sequencer: SFD search, header capture/check,
// PSDU gating, and ownership of the preamble detector enable.
module plcp_rx_controller
  import plcp_pkg::*;
#(
  parameter logic [15:0] SFD_PATTERN = 16'hF3A0,
  parameter int          SFD_TIMEOUT = 64,
  parameter logic [7:0]  SIGNAL_1M   = 8'h0A,
  parameter logic [15:0] MAX_LEN     = 16'd20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_bit,
  input  logic        bit_strobe,
  input  logic        preamble_detected,
  output logic        detector_enable,
  output logic        rx_busy,
  output logic        sfd_found,
  output logic [7:0]  signal_field,
  output logic [7:0]  service_field,
  output logic [15:0] length_field,
  output logic        hdr_valid,
  output logic        psdu_bit,
  output logic        psdu_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic [1:0]  err_code
);

  localparam int SFD_CNT_W = $clog2(SFD_TIMEOUT + 1);
  localparam logic [SFD_CNT_W-1:0] SFD_LIMIT = SFD_CNT_W'(SFD_TIMEOUT);

  plcp_state_t state_reg, state_next;

  logic [15:0]          shift_reg, shift_next;
  logic [SFD_CNT_W-1:0] sfd_cnt_reg, sfd_cnt_next;
  logic [5:0]           hdr_cnt_reg, hdr_cnt_next;
  logic [15:0]          rem_reg, rem_next;
  logic [15:0]          rx_crc_reg, rx_crc_next;
  logic [7:0]           signal_reg, signal_next;
  logic [7:0]           service_reg, service_next;
  logic [15:0]          length_reg, length_next;
  logic [1:0]           err_reg, err_next;

  logic sfd_found_reg, sfd_found_next;
  logic hdr_valid_reg, hdr_valid_next;
  logic psdu_valid_reg, psdu_valid_next;
  logic psdu_bit_reg, psdu_bit_next;
  logic frame_done_reg, frame_done_next;
  logic frame_error_reg, frame_error_next;

  logic        crc_init;
  logic        crc_en;
  logic [15:0] crc_val;

  crc16_ccitt_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .din   (data_bit),
    .crc   (crc_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      sfd_cnt_reg     <= '0;
      hdr_cnt_reg     <= '0;
      rem_reg         <= '0;
      rx_crc_reg      <= '0;
      signal_reg      <= '0;
      service_reg     <= '0;
      length_reg      <= '0;
      err_reg         <= '0;
      sfd_found_reg   <= 1'b0;
      hdr_valid_reg   <= 1'b0;
      psdu_valid_reg  <= 1'b0;
      psdu_bit_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      sfd_cnt_reg     <= sfd_cnt_next;
      hdr_cnt_reg     <= hdr_cnt_next;
      rem_reg         <= rem_next;
      rx_crc_reg      <= rx_crc_next;
      signal_reg      <= signal_next;
      service_reg     <= service_next;
      length_reg      <= length_next;
      err_reg         <= err_next;
      sfd_found_reg   <= sfd_found_next;
      hdr_valid_reg   <= hdr_valid_next;
      psdu_valid_reg  <= psdu_valid_next;
      psdu_bit_reg    <= psdu_bit_next;
      frame_done_reg  <= frame_done_next;
      frame_error_reg <= frame_error_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    sfd_cnt_next     = sfd_cnt_reg;
    hdr_cnt_next     = hdr_cnt_reg;
    rem_next         = rem_reg;
    rx_crc_next      = rx_crc_reg;
    signal_next      = signal_reg;
    service_next     = service_reg;
    length_next      = length_reg;
    err_next         = err_reg;
    sfd_found_next   = 1'b0;
    hdr_valid_next   = 1'b0;
    psdu_valid_next  = 1'b0;
    psdu_bit_next    = 1'b0;
    frame_done_next  = 1'b0;
    frame_error_next = 1'b0;
    crc_init         = 1'b0;
    crc_en           = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (preamble_detected) begin
          state_next    = ST_SFD_SEARCH;
          shift_next    = '0;
          sfd_cnt_next  = '0;
          signal_next   = '0;
          service_next  = '0;
          length_next   = '0;
          crc_init      = 1'b1;
        end
      end

      ST_SFD_SEARCH: begin
        if (bit_strobe) begin
          shift_next   = {data_bit, shift_reg[15:1]};
          sfd_cnt_next = sfd_cnt_reg + SFD_CNT_W'(1);
          // A match on the final allowed strobe still wins over the timeout.
          if (shift_next == SFD_PATTERN) begin
            state_next     = ST_HEADER;
            sfd_found_next = 1'b1;
            hdr_cnt_next   = '0;
          end else if (sfd_cnt_next == SFD_LIMIT) begin
            state_next       = ST_IDLE;
            frame_error_next = 1'b1;
            err_next         = ERR_SFD_TIMEOUT;
          end
        end
      end

      ST_HEADER: begin
        if (bit_strobe) begin
          hdr_cnt_next = hdr_cnt_reg + 6'd1;
          if (hdr_cnt_reg < HDR_CRC_OFS) begin
            crc_en = 1'b1;
          end
          if (hdr_cnt_reg < HDR_SERVICE_OFS) begin
            signal_next = {data_bit, signal_reg[7:1]};
          end else if (hdr_cnt_reg < HDR_LENGTH_OFS) begin
            service_next = {data_bit, service_reg[7:1]};
          end else if (hdr_cnt_reg < HDR_CRC_OFS) begin
            length_next = {data_bit, length_reg[15:1]};
          end else begin
            // Received CRC arrives MSB first.
            rx_crc_next = {rx_crc_reg[14:0], data_bit};
          end
          if (hdr_cnt_reg == HDR_LAST_BIT) begin
            state_next = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        state_next       = ST_IDLE;
        frame_error_next = 1'b1;
        if (~crc_val != rx_crc_reg) begin
          err_next = ERR_CRC;
        end else if (signal_reg != SIGNAL_1M) begin
          err_next = ERR_SIGNAL;
        end else if (length_reg == 16'd0 || length_reg > MAX_LEN) begin
          err_next = ERR_LENGTH;
        end else begin
          frame_error_next = 1'b0;
          hdr_valid_next   = 1'b1;
          rem_next         = length_reg;
          state_next       = ST_PSDU;
        end
      end

      ST_PSDU: begin
        if (bit_strobe) begin
          psdu_valid_next = 1'b1;
          psdu_bit_next   = data_bit;
          if (rem_reg != 16'd0) begin
            rem_next = rem_reg - 16'd1;
          end
          if (rem_reg <= 16'd1) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        frame_done_next = 1'b1;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign detector_enable = (state_reg == ST_IDLE);
  assign rx_busy         = (state_reg != ST_IDLE);
  assign sfd_found       = sfd_found_reg;
  assign signal_field    = signal_reg;
  assign service_field   = service_reg;
  assign length_field    = length_reg;
  assign hdr_valid       = hdr_valid_reg;
  assign psdu_bit        = psdu_bit_reg;
  assign psdu_valid      = psdu_valid_reg;
  assign frame_done      = frame_done_reg;
  assign frame_error     = frame_error_reg;
  assign err_code        = err_reg;

endmodule

// File: tb/tb_plcp_rx_controller.sv
// Scoreboard bench for plcp_rx_controller: stimulus pushes expected events,
// a negedge monitor pops and compares every output pulse.
module tb_plcp_rx_controller;

  localparam int EV_SFD  = 0;
  localparam int EV_HDR  = 1;
  localparam int EV_PSDU = 2;
  localparam int EV_DONE = 3;
  localparam int EV_ERR  = 4;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_bit;
  logic        bit_strobe;
  logic        preamble_detected;
  logic        detector_enable;
  logic        rx_busy;
  logic        sfd_found;
  logic [7:0]  signal_field;
  logic [7:0]  service_field;
  logic [15:0] length_field;
  logic        hdr_valid;
  logic        psdu_bit;
  logic        psdu_valid;
  logic        frame_done;
  logic        frame_error;
  logic [1:0]  err_code;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  plcp_rx_controller dut (
    .clk               (clk),
    .reset             (reset),
    .data_bit          (data_bit),
    .bit_strobe        (bit_strobe),
    .preamble_detected (preamble_detected),
    .detector_enable   (detector_enable),
    .rx_busy           (rx_busy),
    .sfd_found         (sfd_found),
    .signal_field      (signal_field),
    .service_field     (service_field),
    .length_field      (length_field),
    .hdr_valid         (hdr_valid),
    .psdu_bit          (psdu_bit),
    .psdu_valid        (psdu_valid),
    .frame_done        (frame_done),
    .frame_error       (frame_error),
    .err_code          (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input int kind, input logic [31:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event data=%0h, none expected", name, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%0h expected kind=%0d data=%0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sfd_found)   pop_cmp("sfd_found", EV_SFD, 32'd0);
      if (hdr_valid)   pop_cmp("hdr_valid", EV_HDR, {signal_field, service_field, length_field});
      if (psdu_valid)  pop_cmp("psdu_valid", EV_PSDU, {31'd0, psdu_bit});
      if (frame_done)  pop_cmp("frame_done", EV_DONE, 32'd0);
      if (frame_error) pop_cmp("frame_error", EV_ERR, {30'd0, err_code});
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_bit   = b;
    bit_strobe = 1'b1;
    @(negedge clk);
    bit_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_pre();
    @(negedge clk);
    preamble_detected = 1'b1;
    @(negedge clk);
    preamble_detected = 1'b0;
  endtask

  task automatic send_sfd();
    logic [15:0] sfd;
    sfd = 16'hF3A0;
    for (int i = 0; i < 16; i++) send_bit(sfd[i]);
  endtask

  function automatic logic [15:0] hdr_crc(input logic [31:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return ~c;
  endfunction

  // flip < 0 sends the header untouched; otherwise that transmitted bit is inverted.
  task automatic send_header(input logic [7:0] sig, input logic [7:0] svc,
                             input logic [15:0] len, input int flip);
    logic [47:0] hb;
    logic [15:0] c;
    hb[7:0]   = sig;
    hb[15:8]  = svc;
    hb[31:16] = len;
    c = hdr_crc(hb[31:0]);
    for (int k = 0; k < 16; k++) hb[32 + k] = c[15 - k];
    if (flip >= 0) hb[flip] = ~hb[flip];
    for (int i = 0; i < 48; i++) send_bit(hb[i]);
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    chk({name, " pending"}, exp_q.size(), 0);
  endtask

  task automatic frame_to_error(input string name, input logic [7:0] sig,
                                input logic [15:0] len, input int flip, input logic [1:0] code);
    pulse_pre();
    push(EV_SFD, 0);
    send_sfd();
    push(EV_ERR, {30'd0, code});
    send_header(sig, 8'h00, len, flip);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    drain(name);
    chk({name, " detector_enable"}, {31'd0, detector_enable}, 1);
    $display("case %s: err_code=%0d", name, err_code);
  endtask

  initial begin
    logic [9:0]  pre_bits;
    logic [15:0] psdu_a;
    logic [7:0]  psdu_b;

    reset             = 1'b1;
    data_bit          = 1'b0;
    bit_strobe        = 1'b0;
    preamble_detected = 1'b0;
    pre_bits          = 10'b0101010101;
    psdu_a            = 16'hB4C3;
    psdu_b            = 8'h6D;

    repeat (3) @(negedge clk);
    chk("reset detector_enable", {31'd0, detector_enable}, 1);
    chk("reset rx_busy", {31'd0, rx_busy}, 0);
    chk("reset pulses", {26'd0, sfd_found, hdr_valid, psdu_valid, psdu_bit, frame_done, frame_error}, 0);
    chk("reset fields", {signal_field, service_field, length_field}, 0);
    chk("reset err_code", {30'd0, err_code}, 0);
    reset = 1'b0;

    // Nominal frame
    pulse_pre();
    chk("nominal busy", {31'd0, rx_busy}, 1);
    chk("nominal detector off", {31'd0, detector_enable}, 0);
    for (int i = 0; i < 10; i++) send_bit(pre_bits[i]);
    push(EV_SFD, 0);
    send_sfd();
    push(EV_HDR, {8'h0A, 8'h00, 16'd16});
    send_header(8'h0A, 8'h00, 16'd16, -1);
    for (int i = 0; i < 16; i++) push(EV_PSDU, {31'd0, psdu_a[i]});
    push(EV_DONE, 0);
    for (int i = 0; i < 16; i++) send_bit(psdu_a[i]);
    drain("nominal");
    chk("nominal detector_enable", {31'd0, detector_enable}, 1);
    chk("nominal length_field", {16'd0, length_field}, 16);
    $display("case nominal: length=%0d", length_field);

    // SFD timeout after 64 ones
    pulse_pre();
    push(EV_ERR, {30'd0, 2'd0});
    for (int i = 0; i < 64; i++) send_bit(1'b1);
    drain("sfd_timeout");
    chk("sfd_timeout idle", {31'd0, detector_enable}, 1);
    $display("case sfd_timeout: err_code=%0d", err_code);

    // SFD completing on strobe 64, then a 2 Mbps SIGNAL header
    pulse_pre();
    for (int i = 0; i < 48; i++) send_bit(1'b1);
    push(EV_SFD, 0);
    send_sfd();
    chk("sfd64 still busy", {31'd0, rx_busy}, 1);
    push(EV_ERR, {30'd0, 2'd2});
    send_header(8'h14, 8'h00, 16'd16, -1);
    drain("sfd64_signal");
    $display("case sfd64_signal: err_code=%0d", err_code);

    frame_to_error("crc_flip20", 8'h0A, 16'd16, 20, 2'd1);
    frame_to_error("crc_over_signal", 8'h14, 16'd16, 40, 2'd1);
    frame_to_error("len_zero", 8'h0A, 16'd0, -1, 2'd3);
    frame_to_error("len_20001", 8'h0A, 16'd20001, -1, 2'd3);

    // Mid-frame reset after 5 PSDU bits, with a stray preamble pulse in PSDU
    pulse_pre();
    push(EV_SFD, 0);
    send_sfd();
    push(EV_HDR, {8'h0A, 8'h00, 16'd16});
    send_header(8'h0A, 8'h00, 16'd16, -1);
    for (int i = 0; i < 5; i++) push(EV_PSDU, {31'd0, psdu_a[i]});
    for (int i = 0; i < 3; i++) send_bit(psdu_a[i]);
    pulse_pre();
    chk("stray preamble busy", {31'd0, rx_busy}, 1);
    chk("stray preamble detector", {31'd0, detector_enable}, 0);
    for (int i = 3; i < 5; i++) send_bit(psdu_a[i]);
    chk("pre-reset pending", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset detector_enable", {31'd0, detector_enable}, 1);
    chk("midreset rx_busy", {31'd0, rx_busy}, 0);
    chk("midreset pulses", {26'd0, sfd_found, hdr_valid, psdu_valid, psdu_bit, frame_done, frame_error}, 0);
    chk("midreset fields", {signal_field, service_field, length_field}, 0);
    chk("midreset err_code", {30'd0, err_code}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("case midreset: reset applied after 5 PSDU bits");

    // Full frame after recovery
    pulse_pre();
    push(EV_SFD, 0);
    send_sfd();
    push(EV_HDR, {8'h0A, 8'h5C, 16'd8});
    send_header(8'h0A, 8'h5C, 16'd8, -1);
    for (int i = 0; i < 8; i++) push(EV_PSDU, {31'd0, psdu_b[i]});
    push(EV_DONE, 0);
    for (int i = 0; i < 8; i++) send_bit(psdu_b[i]);
    drain("recovery");
    chk("recovery detector_enable", {31'd0, detector_enable}, 1);
    chk("recovery service_field", {24'd0, service_field}, 32'h5C);
    $display("case recovery: length=%0d service=%0h", length_field, service_field);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
